// File: rtl/bitmanip_crc_unit.sv
// bitmanip_crc_unit: iterative CRC32/CRC32C reduction of rs1 for the bitmanip extension.
// Handles BITS_PER_CYCLE bit-steps per clock and holds the result until writeback takes it.
module bitmanip_crc_unit #(
    parameter int BITS_PER_CYCLE = 8,
    parameter int TRANS_ID_BITS  = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [8:0]               operator_i,
    input  logic [63:0]              operand_a_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    output logic [63:0]              result_o,
    output logic                     valid_o,
    input  logic                     result_ready_i,
    output logic [TRANS_ID_BITS-1:0] trans_id_o
);
    localparam int LOG_BPC = $clog2(BITS_PER_CYCLE);
    if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2 && BITS_PER_CYCLE != 4 && BITS_PER_CYCLE != 8) begin : g_bad_bpc
        $error("BITS_PER_CYCLE must be 1, 2, 4 or 8");
    end
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t                   state;
    logic [5:0]               cnt;
    logic [31:0]              poly;
    logic [63:0]              x;
    logic [63:0]              x_step;
    logic [TRANS_ID_BITS-1:0] id;
    logic [6:0]               nsteps;
    logic                     unused_op;
    assign unused_op  = ^operator_i[8:3];
    assign nsteps     = (7'd8 << operator_i[1:0]) >> LOG_BPC;
    assign result_o   = x;
    assign trans_id_o = id;
    // Chained bit steps on the full 64-bit value, so wider operands reduce to a 32-bit CRC.
    always_comb begin
        x_step = x;
        for (int i = 0; i < BITS_PER_CYCLE; i++)
            x_step = (x_step >> 1) ^ ({32'b0, poly} & {64{x_step[0]}});
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            ready_o <= 1'b1;
            valid_o <= 1'b0;
            cnt     <= '0;
            poly    <= '0;
            x       <= '0;
            id      <= '0;
        end else if (flush_i) begin
            state   <= IDLE;
            ready_o <= 1'b1;
            valid_o <= 1'b0;
        end else begin
            case (state)
                IDLE: if (valid_i) begin
                    state   <= BUSY;
                    ready_o <= 1'b0;
                    x       <= operand_a_i;
                    poly    <= operator_i[2] ? 32'h82F63B78 : 32'hEDB88320;
                    id      <= trans_id_i;
                    cnt     <= 6'(nsteps - 7'd1);
                end
                BUSY: begin
                    x <= x_step;
                    if (cnt == '0) begin
                        state   <= DONE;
                        valid_o <= 1'b1;
                    end else begin
                        cnt <= cnt - 6'd1;
                    end
                end
                DONE: if (result_ready_i) begin
                    state   <= IDLE;
                    valid_o <= 1'b0;
                    ready_o <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bitmanip_crc_unit.sv
// tb_bitmanip_crc_unit: directed vectors with hand-computed CRC results, latency,
// backpressure, flush and async reset behaviour.
module tb_bitmanip_crc_unit;
    localparam int BPC = 8;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [8:0]  operator_i = '0;
    logic [63:0] operand_a_i = '0;
    logic [2:0]  trans_id_i = '0;
    logic [63:0] result_o;
    logic        valid_o;
    logic        result_ready_i = 1'b0;
    logic [2:0]  trans_id_o;
    int total = 0;
    int bad = 0;

    bitmanip_crc_unit #(.BITS_PER_CYCLE(BPC), .TRANS_ID_BITS(3)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i),
        .ready_o(ready_o), .operator_i(operator_i), .operand_a_i(operand_a_i),
        .trans_id_i(trans_id_i), .result_o(result_o), .valid_o(valid_o),
        .result_ready_i(result_ready_i), .trans_id_o(trans_id_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [8:0] op, input logic [63:0] a, input logic [2:0] id);
        operator_i  = op;
        operand_a_i = a;
        trans_id_i  = id;
        valid_i     = 1'b1;
        step();
        valid_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int lat = 0;
        while (!valid_o && lat < 200) begin
            step();
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    endtask

    task automatic ack();
        result_ready_i = 1'b1;
        step();
        result_ready_i = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [8:0] op, input logic [63:0] a,
                          input logic [2:0] id, input logic [63:0] exp);
        issue(op, a, id);
        check({tag, " busy ready"}, 64'(ready_o), 64'd0);
        wait_done(tag, (8 << op[1:0]) / BPC);
        check({tag, " result"}, result_o, exp);
        check({tag, " id"}, 64'(trans_id_o), 64'(id));
        ack();
        check({tag, " ack valid"}, 64'(valid_o), 64'd0);
        check({tag, " ack ready"}, 64'(ready_o), 64'd1);
    endtask

    initial begin
        int seen;
        #12;
        check("rst ready", 64'(ready_o), 64'd1);
        check("rst valid", 64'(valid_o), 64'd0);
        check("rst result", result_o, 64'd0);
        check("rst id", 64'(trans_id_o), 64'd0);
        rst_ni = 1'b1;
        step();
        run_op("crc32.b 80", 9'h000, 64'h80, 3'd1, 64'h0000_0000_EDB8_8320);
        run_op("crc32c.b 80", 9'h004, 64'h80, 3'd2, 64'h0000_0000_82F6_3B78);
        run_op("crc32.b 40", 9'h000, 64'h40, 3'd3, 64'h0000_0000_76DC_4190);
        run_op("crc32c.b 40", 9'h004, 64'h40, 3'd4, 64'h0000_0000_417B_1DBC);
        run_op("crc32.h", 9'h001, 64'h8000, 3'd5, 64'h0000_0000_EDB8_8320);
        run_op("crc32c.w", 9'h006, 64'h8000_0000, 3'd6, 64'h0000_0000_82F6_3B78);
        run_op("crc32.d", 9'h003, 64'h8000_0000_0000_0000, 3'd7, 64'h0000_0000_EDB8_8320);
        run_op("crc32.b ff", 9'h000, 64'hFFFF_FFFF_FFFF_FF00, 3'd0, 64'h00FF_FFFF_FFFF_FFFF);
        run_op("hi op bits", 9'h1F8, 64'h80, 3'd1, 64'h0000_0000_EDB8_8320);
        for (int s = 0; s < 4; s++)
            for (int c = 0; c < 2; c++)
                run_op("zero", 9'(c * 4 + s), 64'd0, 3'(s), 64'd0);
        // Backpressure: result must sit still while writeback stalls.
        issue(9'h004, 64'h80, 3'd5);
        wait_done("bp", 1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp valid", 64'(valid_o), 64'd1);
            check("bp result", result_o, 64'h82F6_3B78);
            check("bp id", 64'(trans_id_o), 64'd5);
            check("bp ready", 64'(ready_o), 64'd0);
        end
        ack();
        check("bp ack ready", 64'(ready_o), 64'd1);
        check("bp ack valid", 64'(valid_o), 64'd0);
        // Flush mid-BUSY with a competing valid_i: neither op may produce a result.
        issue(9'h003, 64'h8000_0000_0000_0000, 3'd2);
        step();
        step();
        flush_i = 1'b1;
        valid_i = 1'b1;
        operator_i = 9'h000;
        operand_a_i = 64'h80;
        trans_id_i = 3'd7;
        step();
        flush_i = 1'b0;
        valid_i = 1'b0;
        check("flush ready", 64'(ready_o), 64'd1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (valid_o) seen++;
            step();
        end
        check("flush no valid", 64'(seen), 64'd0);
        check("flush idle", 64'(ready_o), 64'd1);
        // Flush in DONE wins over result_ready_i.
        issue(9'h000, 64'h80, 3'd3);
        wait_done("flush done", 1);
        flush_i = 1'b1;
        result_ready_i = 1'b1;
        step();
        flush_i = 1'b0;
        result_ready_i = 1'b0;
        check("flush done valid", 64'(valid_o), 64'd0);
        check("flush done ready", 64'(ready_o), 64'd1);
        // Async reset mid-BUSY.
        issue(9'h003, 64'h8000_0000_0000_0000, 3'd4);
        step();
        step();
        #2 rst_ni = 1'b0;
        #1;
        check("arst valid", 64'(valid_o), 64'd0);
        check("arst ready", 64'(ready_o), 64'd1);
        check("arst result", result_o, 64'd0);
        check("arst id", 64'(trans_id_o), 64'd0);
        step();
        rst_ni = 1'b1;
        step();
        run_op("post rst", 9'h001, 64'h8000, 3'd6, 64'h0000_0000_EDB8_8320);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
